rps_match_engine: RTL and testbench

RPS_MATCH_ENGINE -- requirements
Module: rps_match_engine

---
 rtl/rps_pkg.sv | 40 ++++
 rtl/rps_round_scorer.sv | 46 ++++
 rtl/rps_match_engine.sv | 109 ++++++++++
 tb/tb_rps_match_engine.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared move/outcome/point encodings, match FSM states and move-relation helpers.
package rps_pkg;

   localparam logic [1:0] INVALID  = 2'b00;
   localparam logic [1:0] ROCK     = 2'b01;
   localparam logic [1:0] PAPER    = 2'b10;
   localparam logic [1:0] SCISSORS = 2'b11;

   localparam logic [1:0] LOSE = 2'b01;
   localparam logic [1:0] DRAW = 2'b10;
   localparam logic [1:0] WIN  = 2'b11;

   localparam int         PTS_W    = 4;
   localparam logic [3:0] PTS_LOSS = 4'd0;
   localparam logic [3:0] PTS_DRAW = 4'd3;
   localparam logic [3:0] PTS_WIN  = 4'd6;

   typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

   // Move that defeats m.
   function automatic logic [1:0] winner_over(input logic [1:0] m);
      case (m)
         ROCK:     return PAPER;
         PAPER:    return SCISSORS;
         SCISSORS: return ROCK;
         default:  return INVALID;
      endcase
   endfunction

   // Move that m defeats.
   function automatic logic [1:0] victim_of(input logic [1:0] m);
      case (m)
         ROCK:     return SCISSORS;
         PAPER:    return ROCK;
         SCISSORS: return PAPER;
         default:  return INVALID;
      endcase
   endfunction

endpackage

// File: rtl/rps_round_scorer.sv
// Combinational single-round resolver: picks player2's move (direct or outcome-driven)
// and returns both players' round points plus an invalid flag.
module rps_round_scorer
   import rps_pkg::*;
(
   input  logic [1:0]       p1_move,
   input  logic [1:0]       p2_code,
   input  logic             mode,
   output logic [PTS_W-1:0] p1_pts,
   output logic [PTS_W-1:0] p2_pts,
   output logic             invalid
);

   logic [1:0]       p2_move;
   logic [PTS_W-1:0] p1_out;
   logic [PTS_W-1:0] p2_out;

   always_comb begin
      p2_move = p2_code;
      if (mode) begin
         case (p2_code)
            LOSE:    p2_move = victim_of(p1_move);
            DRAW:    p2_move = p1_move;
            WIN:     p2_move = winner_over(p1_move);
            default: p2_move = INVALID;
         endcase
      end

      invalid = (p1_move == INVALID) || (p2_code == INVALID);

      if (p1_move == p2_move) begin
         p1_out = PTS_DRAW;
         p2_out = PTS_DRAW;
      end else if (p2_move == victim_of(p1_move)) begin
         p1_out = PTS_WIN;
         p2_out = PTS_LOSS;
      end else begin
         p1_out = PTS_LOSS;
         p2_out = PTS_WIN;
      end

      p1_pts = {2'b00, p1_move} + p1_out;
      p2_pts = {2'b00, p2_move} + p2_out;
   end

endmodule

// File: rtl/rps_match_engine.sv
// Two-stage rock-paper-scissors match scorer: results visible two edges after acceptance.
// in_ready drops during reset, clear, and once the round limit is reached until clear.
module rps_match_engine
   import rps_pkg::*;
#(
   parameter int SCORE_W    = 16,
   parameter int CNT_W      = 16,
   parameter int MAX_ROUNDS = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               mode,
   input  logic [1:0]         player1_input,
   input  logic [1:0]         player2_input,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [SCORE_W-1:0] player1_score,
   output logic [SCORE_W-1:0] player2_score,
   output logic [CNT_W-1:0]   rounds,
   output logic [CNT_W-1:0]   invalid_rounds,
   output logic               done
);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W:0]   LIMIT     = (CNT_W+1)'(MAX_ROUNDS);

   state_t           state, state_nxt;
   logic             accept, last_round;
   logic [CNT_W-1:0] acc_cnt;

   logic [PTS_W-1:0] r_p1_pts, r_p2_pts;
   logic             r_invalid;

   logic             s1_vld, s1_invalid, s1_last;
   logic [PTS_W-1:0] s1_p1_pts, s1_p2_pts;
   logic [SCORE_W:0] p1_sum, p2_sum;

   rps_round_scorer u_scorer (
      .p1_move (player1_input),
      .p2_code (player2_input),
      .mode    (mode),
      .p1_pts  (r_p1_pts),
      .p2_pts  (r_p2_pts),
      .invalid (r_invalid)
   );

   assign in_ready   = (state == RUN) && !clear && !rst;
   assign accept     = in_valid && in_ready;
   // Only valid rounds count toward the limit; a zero limit never matches.
   assign last_round = (MAX_ROUNDS != 0) && !r_invalid &&
                       (({1'b0, acc_cnt} + (CNT_W+1)'(1)) == LIMIT);

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (accept && last_round) state_nxt = DONE;
         DONE:    if (clear) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
      if (clear) state_nxt = RUN;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         s1_vld     <= 1'b0;
         s1_invalid <= 1'b0;
         s1_last    <= 1'b0;
         s1_p1_pts  <= '0;
         s1_p2_pts  <= '0;
         acc_cnt    <= '0;
      end else begin
         s1_vld     <= accept;
         s1_invalid <= r_invalid;
         s1_last    <= accept && last_round;
         s1_p1_pts  <= r_p1_pts;
         s1_p2_pts  <= r_p2_pts;
         if (accept && !r_invalid && (acc_cnt != '1)) acc_cnt <= acc_cnt + CNT_ONE;
      end
   end

   assign p1_sum = {1'b0, player1_score} + (SCORE_W+1)'(s1_p1_pts);
   assign p2_sum = {1'b0, player2_score} + (SCORE_W+1)'(s1_p2_pts);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         player1_score  <= '0;
         player2_score  <= '0;
         rounds         <= '0;
         invalid_rounds <= '0;
         done           <= 1'b0;
      end else if (s1_vld) begin
         if (s1_invalid) begin
            if (invalid_rounds != '1) invalid_rounds <= invalid_rounds + CNT_ONE;
         end else begin
            player1_score <= p1_sum[SCORE_W] ? '1 : p1_sum[SCORE_W-1:0];
            player2_score <= p2_sum[SCORE_W] ? '1 : p2_sum[SCORE_W-1:0];
            if (rounds != '1) rounds <= rounds + CNT_ONE;
            if (s1_last) done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rps_match_engine.sv
// Directed bench: default, 4-bit-score and 2-round-limit engines share one stimulus stream.
module tb_rps_match_engine;
   import rps_pkg::*;

   logic       clk = 1'b0;
   logic       rst, clear, mode, in_valid;
   logic [1:0] p1, p2;

   logic        rdy_a, done_a;
   logic [15:0] s1_a, s2_a, rnd_a, inv_a;
   logic        rdy_b, done_b;
   logic [3:0]  s1_b, s2_b;
   logic [15:0] rnd_b, inv_b;
   logic        rdy_c, done_c;
   logic [15:0] s1_c, s2_c, rnd_c, inv_c;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rps_match_engine dut_a (
      .clk(clk), .rst(rst), .clear(clear), .mode(mode),
      .player1_input(p1), .player2_input(p2), .in_valid(in_valid), .in_ready(rdy_a),
      .player1_score(s1_a), .player2_score(s2_a), .rounds(rnd_a),
      .invalid_rounds(inv_a), .done(done_a)
   );

   rps_match_engine #(.SCORE_W(4)) dut_b (
      .clk(clk), .rst(rst), .clear(clear), .mode(mode),
      .player1_input(p1), .player2_input(p2), .in_valid(in_valid), .in_ready(rdy_b),
      .player1_score(s1_b), .player2_score(s2_b), .rounds(rnd_b),
      .invalid_rounds(inv_b), .done(done_b)
   );

   rps_match_engine #(.MAX_ROUNDS(2)) dut_c (
      .clk(clk), .rst(rst), .clear(clear), .mode(mode),
      .player1_input(p1), .player2_input(p2), .in_valid(in_valid), .in_ready(rdy_c),
      .player1_score(s1_c), .player2_score(s2_c), .rounds(rnd_c),
      .invalid_rounds(inv_c), .done(done_c)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic m);
      in_valid = 1'b1;
      p1       = a;
      p2       = b;
      mode     = m;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear    = 1'b1;
      in_valid = 1'b0;
      tick();
      clear    = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; clear = 1'b0; mode = 1'b0; in_valid = 1'b0; p1 = INVALID; p2 = INVALID;
      tick(); tick();
      check("rst_ready", 32'(rdy_a), 0);
      check("rst_done", 32'(done_a), 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(rdy_a), 1);
      check("post_rst_s1", 32'(s1_a), 0);
      check("post_rst_s2", 32'(s2_a), 0);
      check("post_rst_rounds", 32'(rnd_a), 0);
      check("post_rst_inv", 32'(inv_a), 0);

      // Mode 0, back-to-back: rock/paper, paper/rock, scissors/scissors.
      do_clear();
      drive(ROCK, PAPER, 1'b0);     tick();
      drive(PAPER, ROCK, 1'b0);     tick();
      check("m0_r1_s1", 32'(s1_a), 1);
      check("m0_r1_s2", 32'(s2_a), 8);
      drive(SCISSORS, SCISSORS, 1'b0); tick();
      check("m0_r2_s1", 32'(s1_a), 9);
      check("m0_r2_s2", 32'(s2_a), 9);
      idle(); tick();
      check("m0_r3_s1", 32'(s1_a), 15);
      check("m0_r3_s2", 32'(s2_a), 15);
      check("m0_rounds", 32'(rnd_a), 3);

      // Mode 1: rock vs requested win -> paper.
      do_clear();
      drive(ROCK, WIN, 1'b1); tick();
      idle(); tick();
      check("m1_win_s1", 32'(s1_a), 1);
      check("m1_win_s2", 32'(s2_a), 8);

      // Mode 1: scissors vs requested lose -> paper.
      do_clear();
      drive(SCISSORS, LOSE, 1'b1); tick();
      idle(); tick();
      check("m1_lose_s1", 32'(s1_a), 9);
      check("m1_lose_s2", 32'(s2_a), 2);

      // Invalid player1 code leaves scores and rounds alone.
      drive(INVALID, PAPER, 1'b0); tick();
      idle(); tick();
      check("inv_count", 32'(inv_a), 1);
      check("inv_rounds", 32'(rnd_a), 1);
      check("inv_s1", 32'(s1_a), 9);
      check("inv_s2", 32'(s2_a), 2);

      // 4-bit score saturation: paper vs scissors twice.
      do_clear();
      drive(PAPER, SCISSORS, 1'b0); tick();
      idle(); tick();
      check("sat_r1_s2", 32'(s2_b), 9);
      check("sat_r1_s1", 32'(s1_b), 2);
      drive(PAPER, SCISSORS, 1'b0); tick();
      idle(); tick();
      check("sat_r2_s2", 32'(s2_b), 15);
      check("sat_r2_s1", 32'(s1_b), 4);

      // Two-round limit.
      do_clear();
      drive(ROCK, ROCK, 1'b0);  tick();
      drive(PAPER, ROCK, 1'b0); tick();
      check("lim_ready_low", 32'(rdy_c), 0);
      check("lim_done_early", 32'(done_c), 0);
      check("lim_rounds_1", 32'(rnd_c), 1);
      drive(SCISSORS, ROCK, 1'b0); tick();
      check("lim_done", 32'(done_c), 1);
      check("lim_rounds_2", 32'(rnd_c), 2);
      check("lim_s1", 32'(s1_c), 12);
      check("lim_s2", 32'(s2_c), 5);
      tick();
      check("lim_no_third", 32'(rnd_c), 2);
      check("lim_ready_held", 32'(rdy_c), 0);
      check("lim_done_held", 32'(done_c), 1);

      // Clear with a round offered: not accepted, everything back to zero.
      clear = 1'b1;
      drive(ROCK, PAPER, 1'b0);
      #1;
      check("clr_ready_low", 32'(rdy_c), 0);
      tick();
      clear = 1'b0;
      idle();
      #1;
      check("clr_ready", 32'(rdy_c), 1);
      check("clr_done", 32'(done_c), 0);
      check("clr_s1", 32'(s1_c), 0);
      check("clr_s2", 32'(s2_c), 0);
      check("clr_rounds", 32'(rnd_c), 0);
      check("clr_inv", 32'(inv_c), 0);
      tick(); tick();
      check("clr_not_scored_r", 32'(rnd_c), 0);
      check("clr_not_scored_s2", 32'(s2_c), 0);

      // Reset with a round in flight discards it.
      drive(ROCK, PAPER, 1'b0); tick();
      rst = 1'b1; idle(); tick();
      rst = 1'b0; tick(); tick();
      check("rst_flight_rounds", 32'(rnd_a), 0);
      check("rst_flight_s2", 32'(s2_a), 0);
      check("rst_flight_ready", 32'(rdy_a), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
